prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader; the writer side of instruction memory.
- Receives a length-prefixed program over an 8-bit valid/ready stream (fed by the UART receiver), assembles little-endian 32-bit instruction words and writes them to consecutive imem addresses from 0.
- On completion it releases the core by asserting core_enable. That signal drives the control unit's enable input, so no stores or decode-driven errors occur before the program is resident.

Parameters:
- IMEM_DEPTH, 1024, number of 32-bit words in instruction memory.
- ADDR_W, 10, imem word-address width; must satisfy 2**ADDR_W >= IMEM_DEPTH.

Ports:
- clk  input  1  system clock
- rstN  input  1  reset
- rx_data  input  8  stream byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at posedge clk
- restart  input  1  single-cycle request to reload
- imem_we  output  1  imem write strobe, one cycle per word
- imem_addr  output  ADDR_W  imem word address
- imem_wdata  output  32  instruction word
- busy  output  1  load in progress
- done  output  1  program loaded
- error  output  1  load failed; sticky until restart or reset
- core_enable  output  1  core run enable, equal to done

Behaviour:
- Reset: one clock; rstN asynchronous, active-low. All registers clear immediately when rstN falls. A load in progress is discarded.
- Reset values: FSM=LEN, rx_ready=0 during reset, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, core_enable=0. After release, rx_ready=1 from the first clock.
- All outputs are registered except rx_ready, which is decoded from the state.
- FSM states: LEN, DATA, FLUSH, DONE, ERR.
- LEN
  - rx_ready=1.
  - Collects 4 bytes, LSB first, into word_count[31:0] using a 2-bit byte counter.
  - busy=1 once the first byte is accepted.
  - After byte 4: word_count==0 -> DONE; word_count>IMEM_DEPTH -> ERR; otherwise -> DATA.
- DATA
  - rx_ready=1.
  - Shifts bytes LSB-first into a 32-bit assembly register.
  - On acceptance of byte 4, in the following cycle: imem_we=1 for exactly 1 cycle, imem_wdata=the assembled word, imem_addr=the current word index. The index then increments.
  - Back-to-back words are allowed. The minimum spacing between write pulses is 4 cycles.
  - After the last word's byte 4 -> FLUSH.
- FLUSH
  - rx_ready=0.
  - This is the cycle in which the final imem_we is high.
  - Next cycle -> DONE.
- DONE
  - rx_ready=0, busy=0, done=1, core_enable=1.
  - Extra stream bytes are not accepted (backpressured).
- ERR
  - rx_ready=0, busy=0, error=1, core_enable=0.
  - No further imem writes.
- restart (from any state)
  - Next state is LEN; byte counter, word index and assembly register cleared.
  - done, error and core_enable drop the next cycle.
  - A byte presented in the same cycle as restart is dropped, not consumed.
  - A restart in the same cycle as a 4th-byte acceptance suppresses that word's write.
- Address wrap cannot occur: the length check bounds the word index to IMEM_DEPTH-1.
- rx_valid while rx_ready=0 is held off. Input bytes are sampled only on a handshake.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, the FSM enters state CHK (rx_ready=1) instead of FLUSH.
  - CHK collects a 4-byte LSB-first checksum.
  - The reference sum is the running 32-bit sum of all written words, modulo 2**32.
  - After checksum byte 4: match -> DONE next cycle; mismatch -> ERR.
  - The final data word's imem_we pulse occurs during the first CHK cycle.
  - word_count==0 expects a checksum of 0x00000000.
- Not defined: no CHK state and no sum register; the flow is as described under Behaviour.

Test Plan:
- Nominal load
  - Stimulus: length bytes 02 00 00 00, then 13 05 A0 00, 6F 00 00 00, rx_valid held high.
  - Required: imem_we pulses at addr 0 with data 0x00A00513, then at addr 1 with 0x0000006F. done=1 and core_enable=1 one cycle after the second pulse; rx_ready=0 thereafter.
- Zero length
  - Stimulus: length 00 00 00 00.
  - Required: no imem_we; DONE (with the macro: after checksum 00 00 00 00).
- Oversize
  - Stimulus: length = IMEM_DEPTH+1 (01 04 00 00 at the default).
  - Required: error=1, no imem_we, rx_ready=0, core_enable=0.
- Gapped input
  - Stimulus: random rx_valid gaps during a 3-word load.
  - Required: words written intact, in order, at addresses 0..2.
- Mid-load abort
  - Stimulus: rstN low after 6 bytes; separately, restart pulse after 6 bytes.
  - Required: all outputs at reset values, no write issued. A subsequent full 1-word load succeeds at addr 0.
- With PROG_LOADER_CHECKSUM_EN
  - Stimulus: 2-word load as in the nominal case with checksum 82 05 A0 00 (0x00A00582).
  - Required: DONE.
  - Stimulus: same load with checksum 83 05 A0 00.
  - Required: ERR after both writes; a restart then returns the loader to LEN with error=0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader, the writer side of instruction memory.
//
// Receives a 32-bit little-endian word count followed by that many
// little-endian 32-bit instruction words over an 8-bit valid/ready stream.
// It writes the words to consecutive imem addresses starting at 0, then
// releases the core by raising core_enable.
//
// Optional feature (macro PROG_LOADER_CHECKSUM_EN): after the data words, a
// 4-byte LSB-first checksum follows.  It is compared against the modulo-2**32
// sum of all written words.  A match goes to DONE, a mismatch to ERR.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
// rx_data is sampled only on such an edge.  rx_valid while rx_ready=0 is held off.
//
// Ports:
//   clk          system clock
//   rstN         asynchronous active-low reset
//   rx_data      stream byte
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte (decoded from state)
//   restart      single-cycle reload request, from any state
//   imem_we      imem write strobe, one cycle per word
//   imem_addr    imem word address
//   imem_wdata   instruction word
//   busy         load in progress
//   done         program loaded
//   error        load failed, sticky until restart or reset
//   core_enable  core run enable, equal to done
//   state_dbg_o  current FSM state, for observation

module prog_loader #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              core_enable,
  output logic [2:0]        state_dbg_o
);

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    S_CHK   = 3'd5
`endif
  } state_t;

  localparam logic [31:0] DEPTH32 = 32'(IMEM_DEPTH);

  state_t              state_q;
  logic                run_q;      // low during reset and held low until the first clock after release
  logic [1:0]          cnt_q;      // byte position within the current 4-byte group
  logic [23:0]         asm_q;      // first three bytes of the group; byte 4 is taken straight from rx_data
  logic [31:0]         wcount_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]         sum_q;
`endif

  logic        hs;
  logic [31:0] word_w;
  logic        last_word;

  assign rx_ready  = run_q && ((state_q == S_LEN) || (state_q == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                               || (state_q == S_CHK)
`endif
                              );
  assign hs        = rx_valid && rx_ready;
  // Complete LSB-first word when the 4th byte is on the bus.
  assign word_w    = {rx_data, asm_q};
  assign last_word = (({{(32-ADDR_W){1'b0}}, idx_q} + 32'd1) == wcount_q);

  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign core_enable = done_q;
  assign state_dbg_o = state_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_LEN;
      run_q        <= 1'b0;
      cnt_q        <= 2'd0;
      asm_q        <= 24'd0;
      wcount_q     <= 32'd0;
      idx_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q        <= 32'd0;
`endif
    end else begin
      run_q     <= 1'b1;
      imem_we_q <= 1'b0;
      if (restart) begin
        // Any byte on the bus this cycle is discarded.  A write due from a
        // 4th byte accepted this cycle is also suppressed.
        state_q  <= S_LEN;
        cnt_q    <= 2'd0;
        asm_q    <= 24'd0;
        wcount_q <= 32'd0;
        idx_q    <= '0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        error_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_q    <= 32'd0;
`endif
      end else begin
        case (state_q)
          S_LEN: begin
            if (hs) begin
              busy_q <= 1'b1;
              asm_q  <= {rx_data, asm_q[23:8]};
              cnt_q  <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                wcount_q <= word_w;
                if (word_w == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state_q <= S_CHK;
`else
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
                end else if (word_w > DEPTH32) begin
                  state_q <= S_ERR;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
                end else begin
                  state_q <= S_DATA;
                end
              end
            end
          end
          S_DATA: begin
            if (hs) begin
              asm_q <= {rx_data, asm_q[23:8]};
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= idx_q;
                imem_wdata_q <= word_w;
                idx_q        <= idx_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                sum_q        <= sum_q + word_w;
                if (last_word) state_q <= S_CHK;
`else
                if (last_word) state_q <= S_FLUSH;
`endif
              end
            end
          end
          S_FLUSH: begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (hs) begin
              asm_q <= {rx_data, asm_q[23:8]};
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                busy_q <= 1'b0;
                if (word_w == sum_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_ERR;
                  error_q <= 1'b1;
                end
              end
            end
          end
`endif
          S_DONE:  state_q <= S_DONE;
          S_ERR:   state_q <= S_ERR;
          default: state_q <= S_LEN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: nominal, zero-length, oversize, gapped,
// reset-abort and restart-abort loads.  The optional checksum flow is
// covered when PROG_LOADER_CHECKSUM_EN is defined.

module tb_prog_loader;

  logic        clk;
  logic        rstN;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        restart;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        core_enable;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [41:0] exp_q[$];

  prog_loader #(.IMEM_DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rstN(rstN), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .error(error), .core_enable(core_enable),
    .state_dbg_o(state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $error("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (rstN && imem_we) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("write_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 50) begin
        chk("handshake_timeout", 64'd0, 64'd1);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rstN = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; restart = 1'b0;
    #3;
    // reset state
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_core_en", core_enable, 0);
    chk("rst_state", state_dbg, 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    chk("post_rst_ready_low", rx_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_ready_high", rx_ready, 1);

    // nominal 2-word load, rx_valid held high
    exp_q.push_back({10'd0, 32'h00A00513});
    exp_q.push_back({10'd1, 32'h0000006F});
    send_word(32'h00000002, 0);
    chk("nom_busy", busy, 1);
    send_word(32'h00A00513, 0);
    send_word(32'h0000006F, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("nom_chk_ready", rx_ready, 1);
    chk("nom_chk_we", imem_we, 1);
    send_word(32'h00A00582, 0);
    chk("nom_done", done, 1);
    chk("nom_core_en", core_enable, 1);
`else
    chk("nom_flush_we", imem_we, 1);
    chk("nom_flush_ready", rx_ready, 0);
    chk("nom_flush_done", done, 0);
    @(posedge clk); #1;
    chk("nom_done", done, 1);
    chk("nom_core_en", core_enable, 1);
    chk("nom_busy_low", busy, 0);
`endif
    chk("nom_writes_left", exp_q.size(), 0);
    // extra bytes in DONE are backpressured
    rx_data = 8'h55; rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_backpressure", rx_ready, 0);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("done_hold", done, 1);
    pulse_restart();
    chk("restart_done_low", done, 0);
    chk("restart_core_en_low", core_enable, 0);
    chk("restart_ready", rx_ready, 1);

    // zero length
    send_word(32'h00000000, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'h00000000, 0);
`endif
    chk("zero_done", done, 1);
    chk("zero_error", error, 0);
    chk("zero_ready", rx_ready, 0);
    pulse_restart();

    // oversize: IMEM_DEPTH+1 words
    send_word(32'h00000401, 0);
    chk("over_error", error, 1);
    chk("over_ready", rx_ready, 0);
    chk("over_core_en", core_enable, 0);
    chk("over_busy", busy, 0);
    wait_cycles(3);
    chk("over_error_sticky", error, 1);
    pulse_restart();
    chk("over_restart_error", error, 0);

    // largest legal length is accepted into DATA, then abandoned by restart
    send_word(32'h00000400, 0);
    chk("max_len_state", state_dbg, 1);
    chk("max_len_error", error, 0);
    pulse_restart();

    // gapped 3-word load
    exp_q.push_back({10'd0, 32'h11223344});
    exp_q.push_back({10'd1, 32'hCAFEF00D});
    exp_q.push_back({10'd2, 32'h80000001});
    send_word(32'h00000003, 3);
    send_word(32'h11223344, 3);
    send_word(32'hCAFEF00D, 3);
    send_word(32'h80000001, 3);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'h5C212352, 3);
`endif
    wait_cycles(1);
    chk("gap_done", done, 1);
    chk("gap_writes_left", exp_q.size(), 0);
    pulse_restart();

    // reset abort after 6 bytes
    send_word(32'h00000002, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    rstN = 1'b0;
    #1;
    chk("abort_rst_ready", rx_ready, 0);
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_we", imem_we, 0);
    chk("abort_rst_addr", imem_addr, 0);
    chk("abort_rst_state", state_dbg, 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    wait_cycles(1);
    exp_q.push_back({10'd0, 32'hDEADBEEF});
    send_word(32'h00000001, 0);
    send_word(32'hDEADBEEF, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'hDEADBEEF, 0);
`endif
    wait_cycles(1);
    chk("abort_rst_reload_done", done, 1);
    chk("abort_rst_writes_left", exp_q.size(), 0);
    pulse_restart();

    // restart abort after 6 bytes; a byte offered with restart is dropped
    send_word(32'h00000002, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    rx_data = 8'hAA; rx_valid = 1'b1;
    pulse_restart();
    rx_valid = 1'b0;
    chk("abort_rs_busy", busy, 0);
    chk("abort_rs_done", done, 0);
    chk("abort_rs_error", error, 0);
    chk("abort_rs_we", imem_we, 0);
    chk("abort_rs_state", state_dbg, 0);
    exp_q.push_back({10'd0, 32'h01234567});
    send_word(32'h00000001, 0);
    send_word(32'h01234567, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'h01234567, 0);
`endif
    wait_cycles(1);
    chk("abort_rs_reload_done", done, 1);
    chk("abort_rs_writes_left", exp_q.size(), 0);
    pulse_restart();

`ifdef PROG_LOADER_CHECKSUM_EN
    // checksum mismatch
    exp_q.push_back({10'd0, 32'h00A00513});
    exp_q.push_back({10'd1, 32'h0000006F});
    send_word(32'h00000002, 0);
    send_word(32'h00A00513, 0);
    send_word(32'h0000006F, 0);
    send_word(32'h00A00583, 0);
    chk("cks_bad_error", error, 1);
    chk("cks_bad_done", done, 0);
    chk("cks_bad_writes_left", exp_q.size(), 0);
    pulse_restart();
    chk("cks_bad_restart_error", error, 0);
    chk("cks_bad_restart_state", state_dbg, 0);
`endif

    wait_cycles(2);
    chk("final_writes_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
